// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with stall/flush, optional skid entry, pass-through bits and stall counter
module pipe_stage_reg #(
  parameter int               WIDTH     = 71,
  parameter int               CTRL_W    = 2,
  parameter logic [WIDTH-1:0] PASS_MASK = '0,
  parameter int               SKID      = 0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_stall_cnt
);
  localparam logic [WIDTH-1:0] CTRL_MASK = ~({WIDTH{1'b1}} << CTRL_W);
  if (SKID != 0 && PASS_MASK != '0) begin : g_bad_cfg
    $error("pipe_stage_reg: PASS_MASK must be zero when SKID=1");
  end
  logic             m_valid_q, m_valid_d, s_full_q, s_full_d, accept, consume;
  logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // handshake, main/skid entry next state and saturating stall counter
  always_comb begin
    o_ready   = (SKID != 0) ? ~s_full_q : (~m_valid_q | i_ready);
    accept    = i_valid & o_ready;
    consume   = m_valid_q & i_ready;
    m_valid_d = m_valid_q;
    s_full_d  = s_full_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (i_flush) begin
      m_valid_d = 1'b0;
      s_full_d  = 1'b0;
      m_data_d  = m_data_q & ~CTRL_MASK;
      s_data_d  = s_data_q & ~CTRL_MASK;
    end else if (consume && s_full_q) begin
      m_data_d = s_data_q;
      s_full_d = 1'b0;
    end else if (accept && (!m_valid_q || consume)) begin
      m_valid_d = 1'b1;
      m_data_d  = i_data;
    end else if (accept) begin
      s_full_d = 1'b1;
      s_data_d = i_data;
    end else if (consume) begin
      m_valid_d = 1'b0;
    end
    m_data_d = m_data_d & ~PASS_MASK;
    s_data_d = s_data_d & ~PASS_MASK;
    cnt_d    = i_cnt_clr ? '0 : (m_valid_q & ~i_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_valid_q <= 1'b0;
      s_full_q  <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_full_q  <= s_full_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end
  assign o_valid     = m_valid_q;
  assign o_data      = (i_data & PASS_MASK) | (m_data_q & ~PASS_MASK);
  assign o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of three pipe_stage_reg configurations
module tb_pipe_stage_reg;
  localparam logic [70:0] PM2 = {1'b0, {32{1'b1}}, 38'b0};
  logic clk, nrst;
  logic [2:0] v, r, f, c;
  logic [2:0][70:0] d;
  wire  [2:0] ov, rdy;
  wire  [2:0][70:0] od;
  wire  [2:0][15:0] cnt;
  int n_tests, n_fail;
  always #5 clk = ~clk;
  assign cnt[1][15:4] = '0;
  assign cnt[2][15:4] = '0;
  pipe_stage_reg #(.SKID(0)) u0 (
    .clk(clk), .nrst(nrst), .i_valid(v[0]), .o_ready(rdy[0]), .i_data(d[0]), .o_valid(ov[0]),
    .i_ready(r[0]), .o_data(od[0]), .i_flush(f[0]), .i_cnt_clr(c[0]), .o_stall_cnt(cnt[0]));
  pipe_stage_reg #(.SKID(1), .CNT_W(4)) u1 (
    .clk(clk), .nrst(nrst), .i_valid(v[1]), .o_ready(rdy[1]), .i_data(d[1]), .o_valid(ov[1]),
    .i_ready(r[1]), .o_data(od[1]), .i_flush(f[1]), .i_cnt_clr(c[1]), .o_stall_cnt(cnt[1][3:0]));
  pipe_stage_reg #(.PASS_MASK(PM2), .CNT_W(4)) u2 (
    .clk(clk), .nrst(nrst), .i_valid(v[2]), .o_ready(rdy[2]), .i_data(d[2]), .o_valid(ov[2]),
    .i_ready(r[2]), .o_data(od[2]), .i_flush(f[2]), .i_cnt_clr(c[2]), .o_stall_cnt(cnt[2][3:0]));

  function automatic logic [70:0] rnd71();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[70:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    nrst = 1'b0;
    v = '0; r = '0; f = '0; c = '0; d = '0;
    cyc();
    cyc();
    nrst = 1'b1;
  endtask

  // reference: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1)
  task automatic test_random(int cycles);
    logic [70:0] mem [3][2];
    int n [3];
    int mc [3];
    logic [70:0] pm, exp_d;
    logic exp_rdy, acc, con;
    for (int i = 0; i < 3; i++) begin n[i] = 0; mc[i] = 0; end
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < 3; i++) begin
        d[i] = rnd71();
        v[i] = ($urandom_range(3) != 0);
        r[i] = ($urandom_range(2) != 0);
        f[i] = ($urandom_range(15) == 0);
        c[i] = ($urandom_range(31) == 0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        pm = (i == 2) ? PM2 : '0;
        exp_rdy = (i == 1) ? (n[i] < 2) : (n[i] == 0 || r[i]);
        n_tests++;
        if (rdy[i] !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", i, k, rdy[i], exp_rdy); end
        n_tests++;
        if (ov[i] !== (n[i] > 0)) begin n_fail++; $display("FAIL rand_valid[%0d] cyc %0d: got %b expected %b", i, k, ov[i], n[i] > 0); end
        n_tests++;
        if (cnt[i] !== 16'(mc[i])) begin n_fail++; $display("FAIL rand_cnt[%0d] cyc %0d: got %0d expected %0d", i, k, cnt[i], mc[i]); end
        if (i == 2) begin
          n_tests++;
          if ((od[i] & pm) !== (d[i] & pm)) begin n_fail++; $display("FAIL rand_pass cyc %0d: got %h expected %h", k, od[i] & pm, d[i] & pm); end
        end
        if (n[i] > 0) begin
          exp_d = (mem[i][0] & ~pm) | (d[i] & pm);
          n_tests++;
          if (od[i] !== exp_d) begin n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h expected %h", i, k, od[i], exp_d); end
        end
        acc = v[i] & exp_rdy;
        con = (n[i] > 0) & r[i];
        if (c[i]) mc[i] = 0;
        else if (n[i] > 0 && !r[i] && mc[i] < ((i == 0) ? 65535 : 15)) mc[i]++;
        if (f[i]) n[i] = 0;
        else begin
          if (con) begin mem[i][0] = mem[i][1]; n[i]--; end
          if (acc) begin mem[i][n[i]] = d[i]; n[i]++; end
        end
      end
      cyc();
    end
    v = '0; f = '0; c = '0;
  endtask

  task automatic test_stream0();
    reset_dut();
    for (int k = 1; k <= 8; k++) begin
      v[0] = 1'b1; d[0] = 71'(k); r[0] = 1'b1;
      cyc();
      n_tests++;
      if (ov[0] !== 1'b1 || od[0] !== 71'(k)) begin n_fail++; $display("FAIL stream beat %0d: got v=%b d=%h", k, ov[0], od[0]); end
    end
    v[0] = 1'b0;
    cyc();
    n_tests++;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", ov[0]); end
    reset_dut();
    for (int k = 1; k <= 4; k++) begin
      v[0] = 1'b1; d[0] = 71'(k); r[0] = 1'b1;
      cyc();
    end
    v[0] = 1'b0; r[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b expected 0", rdy[0]); end
      cyc();
      n_tests++;
      if (od[0] !== 71'h4) begin n_fail++; $display("FAIL stall_hold: got %h expected 4", od[0]); end
    end
    n_tests++;
    if (cnt[0] !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 3", cnt[0]); end
  endtask

  task automatic test_skid();
    logic [70:0] a, b;
    reset_dut();
    a = rnd71(); b = rnd71();
    r[1] = 1'b0; v[1] = 1'b1; d[1] = a;
    cyc();
    n_tests++;
    if (ov[1] !== 1'b1 || od[1] !== a || rdy[1] !== 1'b1) begin n_fail++; $display("FAIL skid_a: got v=%b d=%h rdy=%b", ov[1], od[1], rdy[1]); end
    d[1] = b;
    cyc();
    v[1] = 1'b0;
    n_tests++;
    if (od[1] !== a || rdy[1] !== 1'b0) begin n_fail++; $display("FAIL skid_full: got d=%h rdy=%b expected d=%h rdy=0", od[1], rdy[1], a); end
    r[1] = 1'b1;
    cyc();
    n_tests++;
    if (ov[1] !== 1'b1 || od[1] !== b || rdy[1] !== 1'b1) begin n_fail++; $display("FAIL skid_b: got v=%b d=%h rdy=%b expected d=%h", ov[1], od[1], rdy[1], b); end
    cyc();
    n_tests++;
    if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %b expected 0", ov[1]); end
  endtask

  task automatic test_flush();
    reset_dut();
    r[0] = 1'b0; v[0] = 1'b1; d[0] = rnd71() | 71'h3;
    cyc();
    d[0] = rnd71() | 71'h3; f[0] = 1'b1;
    cyc();
    f[0] = 1'b0; v[0] = 1'b0;
    n_tests++;
    if (ov[0] !== 1'b0 || od[0][1:0] !== 2'b00) begin n_fail++; $display("FAIL flush0: got v=%b ctrl=%b expected 0/00", ov[0], od[0][1:0]); end
    r[0] = 1'b1;
    cyc();
    n_tests++;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush0_ghost: got %b expected 0", ov[0]); end
    r[1] = 1'b0; v[1] = 1'b1; d[1] = rnd71() | 71'h3;
    cyc();
    d[1] = rnd71() | 71'h3;
    cyc();
    d[1] = rnd71() | 71'h3; f[1] = 1'b1;
    cyc();
    f[1] = 1'b0; v[1] = 1'b0;
    n_tests++;
    if (ov[1] !== 1'b0 || od[1][1:0] !== 2'b00 || rdy[1] !== 1'b1) begin n_fail++; $display("FAIL flush1: got v=%b ctrl=%b rdy=%b", ov[1], od[1][1:0], rdy[1]); end
    r[1] = 1'b1;
    cyc();
    cyc();
    n_tests++;
    if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL flush1_ghost: got %b expected 0", ov[1]); end
  endtask

  task automatic test_pass();
    logic [70:0] hb, exp_d;
    reset_dut();
    hb = rnd71();
    r[2] = 1'b0; v[2] = 1'b1; d[2] = hb;
    cyc();
    v[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d[2] = rnd71();
      #1;
      exp_d = (d[2] & PM2) | (hb & ~PM2);
      n_tests++;
      if (ov[2] !== 1'b1 || od[2] !== exp_d) begin n_fail++; $display("FAIL pass %0d: got %h expected %h", k, od[2], exp_d); end
      cyc();
    end
  endtask

  task automatic test_counter();
    reset_dut();
    r[1] = 1'b0; v[1] = 1'b1; d[1] = rnd71();
    cyc();
    v[1] = 1'b0;
    repeat (20) cyc();
    n_tests++;
    if (cnt[1] !== 16'd15) begin n_fail++; $display("FAIL cnt_sat: got %0d expected 15", cnt[1]); end
    cyc();
    n_tests++;
    if (cnt[1] !== 16'd15) begin n_fail++; $display("FAIL cnt_hold: got %0d expected 15", cnt[1]); end
    c[1] = 1'b1;
    cyc();
    c[1] = 1'b0;
    n_tests++;
    if (cnt[1] !== 16'd0) begin n_fail++; $display("FAIL cnt_clr: got %0d expected 0", cnt[1]); end
    cyc();
    n_tests++;
    if (cnt[1] !== 16'd1) begin n_fail++; $display("FAIL cnt_after_clr: got %0d expected 1", cnt[1]); end
  endtask

  task automatic test_reset();
    logic [70:0] y;
    reset_dut();
    r[0] = 1'b0; v[0] = 1'b1; d[0] = rnd71();
    cyc();
    v[0] = 1'b0;
    repeat (5) cyc();
    n_tests++;
    if (cnt[0] !== 16'd5 || ov[0] !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got cnt=%0d v=%b expected 5/1", cnt[0], ov[0]); end
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if (ov[0] !== 1'b0 || od[0] !== 71'h0 || cnt[0] !== 16'd0 || rdy[0] !== 1'b1)
      begin n_fail++; $display("FAIL rst_async: got v=%b d=%h cnt=%0d rdy=%b", ov[0], od[0], cnt[0], rdy[0]); end
    n_tests++;
    if (rdy[1] !== 1'b1 || ov[1] !== 1'b0) begin n_fail++; $display("FAIL rst_skid: got rdy=%b v=%b expected 1/0", rdy[1], ov[1]); end
    @(negedge clk);
    y = rnd71();
    v[0] = 1'b1; d[0] = y;
    nrst = 1'b1;
    cyc();
    v[0] = 1'b0;
    n_tests++;
    if (ov[0] !== 1'b1 || od[0] !== y) begin n_fail++; $display("FAIL rst_first_accept: got v=%b d=%h expected %h", ov[0], od[0], y); end
  endtask

  initial begin
    clk = 1'b0; nrst = 1'b0; n_tests = 0; n_fail = 0;
    v = '0; r = '0; f = '0; c = '0; d = '0;
    @(negedge clk);
    reset_dut();
    test_random(400);
    test_stream0();
    test_skid();
    test_flush();
    test_pass();
    test_counter();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
